// File: rtl/instr_stream_encoder_pkg.sv
// Shared constants for the RV32I program loader: opcodes, request classes, FSM states.
package instr_stream_encoder_pkg;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   typedef enum logic [2:0] {
      CLS_R      = 3'd0,
      CLS_I      = 3'd1,
      CLS_LOAD   = 3'd2,
      CLS_STORE  = 3'd3,
      CLS_BRANCH = 3'd4,
      CLS_JAL    = 3'd5,
      CLS_LUI    = 3'd6,
      CLS_ILL    = 3'd7
   } cls_t;

   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_FULL = 2'd2;

endpackage

// File: rtl/instr_stream_encoder_packer.sv
// Combinational field packer: request class + fields -> 32-bit RV32I word.
module instr_field_packer
   import instr_stream_encoder_pkg::*;
(
   input  logic [2:0]  cls,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [2:0]  funct3,
   input  logic        f7b5,
   input  logic [31:0] imm,
   output logic [31:0] word
);

   always_comb begin
      word = 32'd0;
      case (cls)
         CLS_R:      word = {1'b0, f7b5, 5'b0, rs2, rs1, funct3, rd, OPC_R};
         CLS_I: begin
            // shift-immediate forms carry the SRAI select in bit 30, shamt in [24:20]
            if (funct3 == 3'b001 || funct3 == 3'b101)
               word = {1'b0, f7b5, 5'b0, imm[4:0], rs1, funct3, rd, OPC_I};
            else
               word = {imm[11:0], rs1, funct3, rd, OPC_I};
         end
         CLS_LOAD:   word = {imm[11:0], rs1, funct3, rd, OPC_LOAD};
         CLS_STORE:  word = {imm[11:5], rs2, rs1, funct3, imm[4:0], OPC_STORE};
         CLS_BRANCH: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};
         CLS_JAL:    word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
         CLS_LUI:    word = {imm[31:12], rd, OPC_LUI};
         default:    word = 32'd0;
      endcase
   end

endmodule

// File: rtl/instr_stream_encoder.sv
// Program loader: encodes field requests and streams them into instruction memory.
module instr_stream_encoder
   import instr_stream_encoder_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_class,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [2:0]        in_funct3,
   input  logic              in_f7b5,
   input  logic [31:0]       in_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   input  logic              imem_ready,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              full,
   output logic              err
);

   state_t            state;
   logic              out_v;
   logic [ADDR_W-1:0] base_q;
   logic [31:0]       enc;
   logic              done, last, acc;

   instr_field_packer u_packer (
      .cls    (in_class),
      .rd     (in_rd),
      .rs1    (in_rs1),
      .rs2    (in_rs2),
      .funct3 (in_funct3),
      .f7b5   (in_f7b5),
      .imm    (in_imm),
      .word   (enc)
   );

   assign done = out_v && imem_ready;
   assign last = (imem_addr == base_q - ADDR_W'(1));
   // no new word may enter behind the one that fills the final address
   assign in_ready = (state == ST_RUN) && !start && (!out_v || (imem_ready && !last));
   assign acc      = in_valid && in_ready;
   assign imem_we  = out_v;
   assign busy     = (state == ST_RUN);
   assign full     = (state == ST_FULL);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         out_v      <= 1'b0;
         base_q     <= '0;
         imem_addr  <= '0;
         imem_wdata <= 32'd0;
         count      <= '0;
         err        <= 1'b0;
      end else if (start) begin
         state      <= ST_RUN;
         out_v      <= 1'b0;
         base_q     <= base_addr;
         imem_addr  <= base_addr;
         imem_wdata <= 32'd0;
         count      <= '0;
         err        <= 1'b0;
      end else begin
         if (done) begin
            count <= count + (ADDR_W+1)'(1);
            if (last) state <= ST_FULL;
            else      imem_addr <= imem_addr + ADDR_W'(1);
         end
         if (acc && in_class != CLS_ILL) begin
            out_v      <= 1'b1;
            imem_wdata <= enc;
         end else if (done) begin
            out_v <= 1'b0;
         end
         if (acc && in_class == CLS_ILL) err <= 1'b1;
      end
   end

endmodule
